ifu_fetch: RTL and testbench

- Instruction fetch unit upstream of the decode/execute datapath.
- Owns the fetch PC and issues one word-aligned read at a time to instruction memory over a valid/ready request channel plus a response channel.
- Presents the fetched instruction with its PC to the decoder over a valid/ready handshake.
- Accepts PC redirects from execute (jal/jalr/branch) and squashes stale fetches.

---
 rtl/ifu_fetch.sv | 198 +++++++++++++++++++
 tb/tb_ifu_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit feeding decode.
//
// Owns the fetch PC and keeps at most one word read outstanding to
// instruction memory. The fetched word is held for decode, together with
// its PC, until decode consumes it. Execute can redirect the PC at any
// time, and any fetch already in flight is then squashed.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   redirect_valid/_pc        PC change request from execute
//   mem_req_valid/_ready/_addr  read request channel (addr = pc register)
//   mem_rsp_valid/_data/_err    read response channel
//   out_valid/_ready          handshake to decode
//   out_inst/_pc/_fault       instruction, its PC, fault flag
//
// Optional: define IFU_PERF_CNT_EN to add three 64-bit performance counters
// (perf_fetch_cnt, perf_stall_cnt, perf_drop_cnt).
//
// state | meaning
// IDLE  | one cycle after reset release
// REQ   | driving a read request at pc
// WAIT  | one request outstanding, waiting for its response
// HOLD  | instruction (or fault) presented to decode

module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
`ifdef IFU_PERF_CNT_EN
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt,
  output logic [63:0] perf_drop_cnt,
`endif
  output logic        out_fault
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] opc_q, opc_d;
  logic        drop_q, drop_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic        go_fault;
  logic        rsp_discard;
  logic        hold_discard;
  logic        out_hs;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    opc_d        = opc_q;
    drop_d       = drop_q;
    valid_d      = valid_q;
    fault_d      = fault_q;
    go_fault     = 1'b0;
    rsp_discard  = 1'b0;
    hold_discard = 1'b0;
    out_hs       = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) begin
          pc_d     = redirect_pc;
          go_fault = (redirect_pc[1:0] != 2'b00);
        end
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (mem_req_ready) begin
            // The accepted request belongs to the old path; squash its response.
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            go_fault = (redirect_pc[1:0] != 2'b00);
          end
        end else if (mem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            rsp_discard = 1'b1;
            drop_d      = 1'b0;
            if (redirect_valid) pc_d = redirect_pc;
            state_d  = S_REQ;
            // A misaligned target deferred behind a squashed fetch faults here.
            go_fault = (pc_d[1:0] != 2'b00);
          end else begin
            inst_d  = mem_rsp_err ? NOP_INST : mem_rsp_data;
            opc_d   = pc_q;
            fault_d = mem_rsp_err;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          pc_d   = redirect_pc;
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          hold_discard = 1'b1;
          valid_d      = 1'b0;
          pc_d         = redirect_pc;
          state_d      = S_REQ;
          go_fault     = (redirect_pc[1:0] != 2'b00);
        end else if (out_ready) begin
          out_hs  = 1'b1;
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Misaligned targets never reach memory; present a faulted NOP instead.
    if (go_fault) begin
      state_d = S_HOLD;
      valid_d = 1'b1;
      fault_d = 1'b1;
      inst_d  = NOP_INST;
      opc_d   = pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      opc_q   <= 32'd0;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      opc_q   <= opc_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = pc_q;
  assign out_valid     = valid_q;
  assign out_inst      = inst_q;
  assign out_pc        = opc_q;
  assign out_fault     = fault_q;

`ifdef IFU_PERF_CNT_EN
  logic [63:0] fetch_cnt_q, stall_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= 64'd0;
      stall_cnt_q <= 64'd0;
      drop_cnt_q  <= 64'd0;
    end else begin
      if (out_hs) fetch_cnt_q <= fetch_cnt_q + 64'd1;
      if ((state_q == S_REQ) || (state_q == S_WAIT)) stall_cnt_q <= stall_cnt_q + 64'd1;
      if (rsp_discard || hold_discard) drop_cnt_q <= drop_cnt_q + 64'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = out_hs ^ rsp_discard ^ hold_discard;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  bit          auto_mem;
  logic [31:0] err_addr;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  ifu_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_fault     (out_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; the zero-wait memory model answers an accepted request on the next cycle.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = mem_req_valid && mem_req_ready;
    a   = mem_req_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      mem_rsp_valid = acc;
      mem_rsp_data  = a ^ KEY;
      mem_rsp_err   = acc && (a == err_addr);
    end
  endtask

  task automatic wait_out(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 20);
    chk(tag, n, exp_n);
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'd0;
    mem_rsp_err    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    auto_mem      = 1'b1;
    err_addr      = 32'hFFFF_FFFF;
    out_ready     = 1'b1;
    mem_req_ready = 1'b1;
    do_reset();
    rst = 1'b0;
    #1;
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_fault", out_fault, 0);
    do_reset();

    // zero-wait stream, one instruction every 3 cycles
    tick();
    chk("first_req_valid", mem_req_valid, 1);
    chk("first_req_addr", mem_req_addr, 32'h8000_0000);
    wait_out("first_latency", 2);
    chk("s0_pc", out_pc, 32'h8000_0000);
    chk("s0_inst", out_inst, 32'h25A5_0000);
    wait_out("s1_period", 3);
    chk("s1_pc", out_pc, 32'h8000_0004);
    chk("s1_inst", out_inst, 32'h25A5_0004);
    wait_out("s2_period", 3);
    chk("s2_pc", out_pc, 32'h8000_0008);
    chk("s2_inst", out_inst, 32'h25A5_0008);
    chk("s2_fault", out_fault, 0);

    // request stalled by mem_req_ready low
    mem_req_ready = 1'b0;
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", mem_req_valid, 1);
      chk("stall_addr", mem_req_addr, 32'h8000_0000);
    end
    mem_req_ready = 1'b1;
    wait_out("stall_latency", 2);
    chk("stall_out_pc", out_pc, 32'h8000_0000);

    // redirect in WAIT, stale response arrives later
    auto_mem = 1'b0;
    tick();
    tick();
    chk("wait_req_valid", mem_req_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    mem_rsp_valid  = 1'b1;
    mem_rsp_data   = 32'hDEAD_BEEF;
    mem_rsp_err    = 1'b0;
    tick();
    mem_rsp_valid = 1'b0;
    chk("stale_out_valid", out_valid, 0);
    chk("stale_req_valid", mem_req_valid, 1);
    chk("stale_req_addr", mem_req_addr, 32'h8000_0100);
    auto_mem = 1'b1;
    wait_out("redir_latency", 2);
    chk("redir_out_pc", out_pc, 32'h8000_0100);
    chk("redir_out_inst", out_inst, 32'h25A5_0100);

    // redirect in HOLD beats out_ready
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0040;
    tick();
    redirect_valid = 1'b0;
    chk("hold_redir_valid", out_valid, 0);
    chk("hold_redir_addr", mem_req_addr, 32'h8000_0040);
    wait_out("hold_redir_lat", 2);
    chk("hold_redir_pc", out_pc, 32'h8000_0040);

    // misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0042;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    chk("mis_req_valid", mem_req_valid, 0);
    chk("mis_out_valid", out_valid, 1);
    chk("mis_fault", out_fault, 1);
    chk("mis_inst", out_inst, 32'h0000_0013);
    chk("mis_pc", out_pc, 32'h8000_0042);
    tick();
    chk("mis_hold_req", mem_req_valid, 0);
    chk("mis_hold_pc", out_pc, 32'h8000_0042);

    // access fault on fetch of 0x80000008
    err_addr       = 32'h8000_0008;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0008;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    wait_out("err_latency", 2);
    chk("err_fault", out_fault, 1);
    chk("err_inst", out_inst, 32'h0000_0013);
    chk("err_pc", out_pc, 32'h8000_0008);

    // pc wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    wait_out("wrap_latency", 2);
    chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap_inst", out_inst, 32'h5A5A_FFFC);
    chk("wrap_fault", out_fault, 0);
    tick();
    chk("wrap_next_addr", mem_req_addr, 32'h0000_0000);

    // async reset while WAIT
    tick();
    rst = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    chk("midrst_req_valid", mem_req_valid, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_inst", out_inst, 0);
    chk("midrst_out_pc", out_pc, 0);
    chk("midrst_out_fault", out_fault, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("restart_addr", mem_req_addr, 32'h8000_0000);
    wait_out("restart_latency", 2);
    chk("restart_pc", out_pc, 32'h8000_0000);
    chk("restart_inst", out_inst, 32'h25A5_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
